// File: rtl/ghr_pkg.sv
// rtl/ghr_pkg.sv - shared types and defaults for the speculative global-history controller
package ghr_pkg;

  localparam int GHR_W_DEF = 8;

  typedef enum logic [2:0] {
    EVT_NONE,
    EVT_PUSH,
    EVT_POP,
    EVT_PUSHPOP,
    EVT_REPAIR
  } ghr_evt_e;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// rtl/ghr_ckpt_fifo.sv - checkpoint FIFO holding the history each in-flight branch predicted with
module ghr_ckpt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  // Next-state for pointers, count and storage; clear realigns read onto write
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = din_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_i && !pop_i) begin
        cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop_i && !push_i) begin
        cnt_d = cnt_q - (PW+1)'(1);
      end
    end
  end

  // State registers; storage is reset so the head never reads as X
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ghr_spec_ctrl.sv
// rtl/ghr_spec_ctrl.sv - speculative and committed GHR with per-branch checkpoint repair
module ghr_spec_ctrl
  import ghr_pkg::*;
#(
  parameter int HISTORY_WIDTH = GHR_W_DEF,
  parameter int CKPT_DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fetch_br_valid_i,
  input  logic                          fetch_pred_taken_i,
  input  logic                          res_valid_i,
  input  logic                          res_taken_i,
  input  logic                          res_mispred_i,
  input  logic                          flush_i,
  output logic [HISTORY_WIDTH-1:0]      ghr_spec_o,
  output logic [HISTORY_WIDTH-1:0]      ghr_commit_o,
  output logic [HISTORY_WIDTH-1:0]      res_hist_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_cnt_o,
  output logic                          err_o
);

  localparam int CW = $clog2(CKPT_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(CKPT_DEPTH);

  logic [HISTORY_WIDTH-1:0] ghr_spec_q, ghr_spec_d;
  logic [HISTORY_WIDTH-1:0] ghr_commit_q, ghr_commit_d;
  logic                     err_q, err_d;
  logic [CW-1:0]            cnt;
  logic                     full, empty;
  logic                     res_ok, mispred, push_ok;
  logic                     fifo_push, fifo_pop, fifo_clear;
  ghr_evt_e                 evt;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  // A resolve with nothing in flight is a protocol error and is ignored entirely
  assign res_ok  = res_valid_i & ~empty;
  assign mispred = res_ok & res_mispred_i;
  assign push_ok = fetch_br_valid_i & ~full;

  // Priority decode: repair (mispredict or flush) overrides any push/pop this cycle
  always_comb begin
    evt = EVT_NONE;
    if (mispred || flush_i) begin
      evt = EVT_REPAIR;
    end else if (push_ok && res_ok) begin
      evt = EVT_PUSHPOP;
    end else if (push_ok) begin
      evt = EVT_PUSH;
    end else if (res_ok) begin
      evt = EVT_POP;
    end
  end

  assign fifo_push  = (evt == EVT_PUSH) || (evt == EVT_PUSHPOP);
  assign fifo_pop   = (evt == EVT_POP)  || (evt == EVT_PUSHPOP);
  assign fifo_clear = (evt == EVT_REPAIR);

  // GHR next-state: commit follows every valid resolve; repair reloads spec from the new commit
  always_comb begin
    ghr_commit_d = ghr_commit_q;
    ghr_spec_d   = ghr_spec_q;
    err_d        = err_q | (fetch_br_valid_i & full) | (res_valid_i & empty);
    if (res_ok) begin
      ghr_commit_d = {ghr_commit_q[HISTORY_WIDTH-2:0], res_taken_i};
    end
    if (evt == EVT_REPAIR) begin
      ghr_spec_d = ghr_commit_d;
    end else if (fifo_push) begin
      ghr_spec_d = {ghr_spec_q[HISTORY_WIDTH-2:0], fetch_pred_taken_i};
    end
  end

  // History and sticky error registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_spec_q   <= '0;
      ghr_commit_q <= '0;
      err_q        <= 1'b0;
    end else begin
      ghr_spec_q   <= ghr_spec_d;
      ghr_commit_q <= ghr_commit_d;
      err_q        <= err_d;
    end
  end

  ghr_ckpt_fifo #(
    .W     (HISTORY_WIDTH),
    .DEPTH (CKPT_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (fifo_clear),
    .din_i   (ghr_spec_q),
    .head_o  (res_hist_o),
    .cnt_o   (cnt)
  );

  assign ghr_spec_o   = ghr_spec_q;
  assign ghr_commit_o = ghr_commit_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign ckpt_cnt_o   = cnt;
  assign err_o        = err_q;

endmodule
